wb_spi_master: RTL and testbench
================================

# wb_spi_master

Wishbone-slave SPI master, the parametrised successor of the fixed three-device SPI port. It sits on the Wishbone data bus next to the other peripherals and adds the following:
- a configurable number of chip selects;
- a runtime-programmable SCLK divider;
- all four CPOL/CPHA modes and LSB-first shifting;
- a readable receive register.

A write to the data window starts one full-duplex 8/16/32-bit transfer. `ack_o` is held back until the transfer has completed.

## Interface
- `N_CS`, 3: number of chip selects, 1..8.
- `DEFAULT_DIV`, 1: reset value of `CFG.div`.
- `DEFAULT_CPOL`, 0: reset value of `CFG.cpol`.
- `DEFAULT_CPHA`, 0: reset value of `CFG.cpha`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `adr_i`  in  32  byte address; only bits [7:4] are decoded.
- `dat_i`  in  32  write data.
- `we_i`  in  1  write enable.
- `sel_i`  in  4  byte select; also sets the transfer width.
- `stb_i`, `cyc_i`  in  1 each  Wishbone strobe and cycle.
- `ack_o`  out  1  one-cycle acknowledge pulse.
- `dat_o`  out  32  read data.
- `spi_clk_o`  out  1  SCLK.
- `spi_data_o`  out  1  MOSI.
- `spi_data_i`  in  1  MISO.
- `spi_cs_n_o`  out  N_CS  chip selects, active-low.

## Operation
Address decode:
- `adr_i[7]=1` selects CFG.
  - Layout: [7:0] `div`, [8] `cpol`, [9] `cpha`, [10] `lsb_first`. Other bits read 0.
  - Reads and writes both ack the cycle after the request. Writes honour `sel_i` per byte.
- `adr_i[7]=0` selects DATA.
  - Reads ack the next cycle and return RX.
  - Writes start a transfer. `adr_i[6:4]` is the CS index.
  - An index ≥ N_CS runs the transfer with every CS held high.

Transfer width W comes from `sel_i`:
- 4'b1111 gives 32.
- 4'b0011 gives 16, with data in `dat_i[15:0]`.
- 4'b0001 gives 8, with data in `dat_i[7:0]`.
- Any other value acks next cycle with no transfer and leaves RX unchanged.

Data ordering:
- TX is left-aligned for MSB-first and right-aligned for LSB-first.
- Received bits land in RX right-aligned and zero-extended. The first received bit is the MSB of the W-bit value when MSB-first.

FSM states: IDLE, SETUP, LEAD, TRAIL, HOLD. Every state except IDLE lasts H = `div`+1 clk cycles, counted by a half-period counter.
- IDLE: accepts a request when `stb_i & cyc_i`. Transitions go to SETUP (valid write) or stay in IDLE with ack (all others). On a valid write: latch CS, W, the shift register and the mode bits, then assert the selected `spi_cs_n_o`.
- SETUP: SCLK stays idle (= `cpol`). With `cpha`=0 the first bit is driven here.
- LEAD: SCLK = !`cpol`.
  - `cpha`=0: sample MISO at entry.
  - `cpha`=1: shift out the next bit at entry.
- TRAIL: SCLK = `cpol`.
  - `cpha`=0: shift out at entry.
  - `cpha`=1: sample at entry.
  - After W LEAD/TRAIL pairs, go to HOLD.
- HOLD: SCLK idle. At exit: CS goes high, `ack_o`=1 and RX is valid on `dat_o` in the same cycle, and the FSM returns to IDLE.

Other rules:
- CFG is latched at transfer start, so a CFG write cannot occur mid-transfer: the bus is stalled.
- Dropping `cyc_i` mid-transfer does not abort. The transfer completes and `ack_o` still pulses.
- `spi_data_o` = 0 while IDLE.

## Timing
Reset values:
- `ack_o`=0, `dat_o`=0 (RX=0), `spi_cs_n_o` all 1.
- `spi_clk_o`=`DEFAULT_CPOL`, `spi_data_o`=0.
- CFG = {`lsb_first`=0, `DEFAULT_CPHA`, `DEFAULT_CPOL`, `DEFAULT_DIV`}.

Cycle timing:
- Accept edge T: CS falls at T+1.
- First SCLK edge at T+1+H.
- `ack_o` and CS rise together at T+(2W+2)·H.
- Example: div=1, W=8 gives ack at T+36.
- Non-transfer accesses ack at T+1.
- Only one request is ever in flight. A new request is accepted earliest in the cycle after `ack_o`.
- Asserting `rst_n` low mid-transfer forces all outputs to their reset values immediately. The transfer is lost.

## Structure
- Shared include `wb_spi_defs.vh`: FSM state encodings, CFG bit positions, the `adr_i` decode bit positions, and the width codes.
- One sub-module, `spi_shift_engine`: the shift register, bit counter and MSB/LSB-first handling. Its interface is load, shift, sample and done.
- The top level holds the Wishbone decode, CFG register, half-period counter and FSM.

## Test plan
- Reset defaults: CS all 1, SCLK=0, read of CFG returns 0x001, read of DATA returns 0.
- Mode 0, div=1, CS 1, sel=0001, `dat_i`=0xA5, MISO loopback: MOSI bits 1,0,1,0,0,1,0,1; only `spi_cs_n_o[1]`=0; ack at T+36; RX=0xA5.
- CFG=0x703 (div=3, mode 3, LSB-first), 16-bit 0x1234 with MISO tied 1: SCLK idles high with period 8 clk; MOSI LSB-first; ack at T+136; RX=0xFFFF.
- 32-bit 0xDEADBEEF to CS index 7 with N_CS=3: no CS asserts; 32 SCLK pulses; ack; next transfer accepted the cycle after ack.
- sel=0110 write: ack at T+1, no SCLK activity, RX unchanged.
- `rst_n` pulsed low at mid-transfer bit 5: outputs return to reset values asynchronously, no ack, and the next write completes normally.

Source files
------------

// File: rtl/wb_spi_master_pkg.sv
// Shared definitions for wb_spi_master: FSM states, CFG layout, address decode
// positions and transfer width codes.
package wb_spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LEAD  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    W_8   = 2'd0,
    W_16  = 2'd1,
    W_32  = 2'd2,
    W_BAD = 2'd3
  } width_e;

  // Packed to match the CFG register image bit-for-bit: [10] lsb, [9] cpha, [8] cpol, [7:0] div.
  typedef struct packed {
    logic       lsb_first;
    logic       cpha;
    logic       cpol;
    logic [7:0] div;
  } cfg_t;

  localparam int CFG_CPOL_BIT = 8;
  localparam int CFG_CPHA_BIT = 9;
  localparam int CFG_LSB_BIT  = 10;
  localparam int ADR_CFG_BIT  = 7;
  localparam int ADR_CS_LSB   = 4;

  function automatic width_e decode_sel(input logic [3:0] sel);
    case (sel)
      4'b1111: return W_32;
      4'b0011: return W_16;
      4'b0001: return W_8;
      default: return W_BAD;
    endcase
  endfunction

  function automatic logic [5:0] width_bits(input width_e w);
    case (w)
      W_8:     return 6'd8;
      W_16:    return 6'd16;
      W_32:    return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/wb_spi_master_shift_engine.sv
// SPI shift engine: TX pop register driving MOSI, RX assembly and sample counter.
// Each shift pops the head bit onto MOSI; shifted-in zeros return MOSI low at the end.
module spi_shift_engine
  import wb_spi_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic        sample_i,
  input  logic        lsb_first_i,
  input  logic        cpha_i,
  input  width_e      width_i,
  input  logic [31:0] tx_i,
  input  logic        miso_i,
  output logic        mosi_o,
  output logic [31:0] rx_o,
  output logic        done_o
);

  logic [31:0] sr_q, sr_d, rx_q, rx_d, aligned_s;
  logic        mosi_q, mosi_d, lsb_q, lsb_d;
  logic [5:0]  bits_q, bits_d;
  width_e      w_q, w_d;

  function automatic logic head(input logic [31:0] v, input logic lsb);
    return lsb ? v[0] : v[31];
  endfunction

  function automatic logic [31:0] advance(input logic [31:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [31:0] sample_in(input logic [31:0] v, input logic b,
                                            input logic lsb, input width_e w);
    if (!lsb) begin
      return {v[30:0], b};
    end else begin
      case (w)
        W_8:     return {24'd0, b, v[7:1]};
        W_16:    return {16'd0, b, v[15:1]};
        default: return {b, v[31:1]};
      endcase
    end
  endfunction

  always_comb begin
    case (width_i)
      W_8:     aligned_s = lsb_first_i ? {24'd0, tx_i[7:0]}  : {tx_i[7:0], 24'd0};
      W_16:    aligned_s = lsb_first_i ? {16'd0, tx_i[15:0]} : {tx_i[15:0], 16'd0};
      W_32:    aligned_s = tx_i;
      default: aligned_s = 32'd0;
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    rx_d   = rx_q;
    mosi_d = mosi_q;
    bits_d = bits_q;
    lsb_d  = lsb_q;
    w_d    = w_q;
    if (load_i) begin
      // With cpha=0 the first bit is popped onto MOSI at load time.
      sr_d   = cpha_i ? aligned_s : advance(aligned_s, lsb_first_i);
      mosi_d = cpha_i ? 1'b0 : head(aligned_s, lsb_first_i);
      rx_d   = 32'd0;
      bits_d = 6'd0;
      lsb_d  = lsb_first_i;
      w_d    = width_i;
    end else begin
      sr_d   = shift_i  ? advance(sr_q, lsb_q) : sr_q;
      mosi_d = shift_i  ? head(sr_q, lsb_q) : mosi_q;
      rx_d   = sample_i ? sample_in(rx_q, miso_i, lsb_q, w_q) : rx_q;
      bits_d = sample_i ? bits_q + 6'd1 : bits_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= 32'd0;
      rx_q   <= 32'd0;
      mosi_q <= 1'b0;
      bits_q <= 6'd0;
      lsb_q  <= 1'b0;
      w_q    <= W_8;
    end else begin
      sr_q   <= sr_d;
      rx_q   <= rx_d;
      mosi_q <= mosi_d;
      bits_q <= bits_d;
      lsb_q  <= lsb_d;
      w_q    <= w_d;
    end
  end

  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;
  assign done_o = (bits_q == width_bits(w_q));

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone-slave SPI master: bus decode, CFG register, half-period counter and
// transfer FSM. DATA writes stall the bus until the transfer completes.
module wb_spi_master
  import wb_spi_master_pkg::*;
#(
  parameter int N_CS         = 3,
  parameter int DEFAULT_DIV  = 1,
  parameter int DEFAULT_CPOL = 0,
  parameter int DEFAULT_CPHA = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     adr_i,
  input  logic [31:0]     dat_i,
  input  logic            we_i,
  input  logic [3:0]      sel_i,
  input  logic            stb_i,
  input  logic            cyc_i,
  output logic            ack_o,
  output logic [31:0]     dat_o,
  output logic            spi_clk_o,
  output logic            spi_data_o,
  input  logic            spi_data_i,
  output logic [N_CS-1:0] spi_cs_n_o
);

  localparam cfg_t CFG_RST = {1'b0, 1'(DEFAULT_CPHA), 1'(DEFAULT_CPOL), 8'(DEFAULT_DIV)};
  localparam logic [N_CS-1:0] CS_OFF = {N_CS{1'b1}};

  state_e          state_q, state_d;
  logic [7:0]      hcnt_q, hcnt_d;
  cfg_t            cfg_q, cfg_d, act_q, act_d;
  logic [N_CS-1:0] cs_mask_q, cs_mask_d, cs_n_q, cs_n_d;
  logic            ack_q, ack_d, sclk_q, sclk_d;
  logic [31:0]     dat_o_q, dat_o_d, rx_s;
  logic            req_s, start_s, cfg_wr_s, rd_s, phase_end_s, last_hold_s, idle_ack_s;
  logic            load_s, shift_s, sample_s, done_s, unused_adr_s;
  width_e          wsel_s;

  assign wsel_s       = decode_sel(sel_i);
  assign req_s        = stb_i & cyc_i & ~ack_q;
  assign start_s      = req_s & we_i & ~adr_i[ADR_CFG_BIT] & (wsel_s != W_BAD);
  assign cfg_wr_s     = req_s & we_i & adr_i[ADR_CFG_BIT];
  assign rd_s         = req_s & ~we_i & (state_q == ST_IDLE);
  assign phase_end_s  = (hcnt_q == act_q.div);
  assign unused_adr_s = ^{adr_i[31:8], adr_i[3:0]};

  // Next-state, strobes to the shift engine and registered output values.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    act_d      = act_q;
    cs_mask_d  = cs_mask_q;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    sample_s   = 1'b0;
    idle_ack_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d   = ST_SETUP;
          load_s    = 1'b1;
          act_d     = cfg_q;
          // Indices beyond N_CS shift the one out of range, leaving every CS high.
          cs_mask_d = ~(N_CS'(1'b1) << adr_i[ADR_CS_LSB +: 3]);
        end else begin
          idle_ack_s = req_s;
        end
        cfg_d.div       = (cfg_wr_s && sel_i[0]) ? dat_i[7:0]            : cfg_q.div;
        cfg_d.cpol      = (cfg_wr_s && sel_i[1]) ? dat_i[CFG_CPOL_BIT]   : cfg_q.cpol;
        cfg_d.cpha      = (cfg_wr_s && sel_i[1]) ? dat_i[CFG_CPHA_BIT]   : cfg_q.cpha;
        cfg_d.lsb_first = (cfg_wr_s && sel_i[1]) ? dat_i[CFG_LSB_BIT]    : cfg_q.lsb_first;
      end
      ST_SETUP: begin
        state_d  = phase_end_s ? ST_LEAD : ST_SETUP;
        sample_s = phase_end_s & ~act_q.cpha;
        shift_s  = phase_end_s & act_q.cpha;
      end
      ST_LEAD: begin
        state_d  = phase_end_s ? ST_TRAIL : ST_LEAD;
        shift_s  = phase_end_s & ~act_q.cpha;
        sample_s = phase_end_s & act_q.cpha;
      end
      ST_TRAIL: begin
        state_d  = phase_end_s ? (done_s ? ST_HOLD : ST_LEAD) : ST_TRAIL;
        shift_s  = phase_end_s & act_q.cpha;
        sample_s = phase_end_s & ~act_q.cpha & ~done_s;
      end
      ST_HOLD: begin
        state_d = phase_end_s ? ST_IDLE : ST_HOLD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    hcnt_d      = ((state_q == ST_IDLE) || phase_end_s) ? 8'd0 : hcnt_q + 8'd1;
    // The final HOLD cycle carries ack, released CS and RX together.
    last_hold_s = (state_d == ST_HOLD) && (hcnt_d == act_d.div);
    ack_d       = idle_ack_s | last_hold_s;
    cs_n_d      = ((state_d != ST_IDLE) && !last_hold_s) ? cs_mask_d : CS_OFF;
    sclk_d      = (state_d == ST_LEAD) ? ~act_d.cpol :
                  ((state_d == ST_IDLE) ? cfg_d.cpol : act_d.cpol);
    dat_o_d     = last_hold_s ? rx_s :
                  (rd_s ? (adr_i[ADR_CFG_BIT] ? {21'd0, cfg_q} : rx_s) : dat_o_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= 8'd0;
      cfg_q     <= CFG_RST;
      act_q     <= CFG_RST;
      cs_mask_q <= CS_OFF;
      cs_n_q    <= CS_OFF;
      ack_q     <= 1'b0;
      sclk_q    <= CFG_RST.cpol;
      dat_o_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      cfg_q     <= cfg_d;
      act_q     <= act_d;
      cs_mask_q <= cs_mask_d;
      cs_n_q    <= cs_n_d;
      ack_q     <= ack_d;
      sclk_q    <= sclk_d;
      dat_o_q   <= dat_o_d;
    end
  end

  spi_shift_engine u_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_s),
    .shift_i     (shift_s),
    .sample_i    (sample_s),
    .lsb_first_i (cfg_q.lsb_first),
    .cpha_i      (cfg_q.cpha),
    .width_i     (wsel_s),
    .tx_i        (dat_i),
    .miso_i      (spi_data_i),
    .mosi_o      (spi_data_o),
    .rx_o        (rx_s),
    .done_o      (done_s)
  );

  assign ack_o      = ack_q;
  assign dat_o      = dat_o_q;
  assign spi_clk_o  = sclk_q;
  assign spi_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_wb_spi_master.sv
// Directed bench for wb_spi_master with a scoreboard queue of expected results.
module tb_wb_spi_master;

  localparam int N_CS = 3;
  localparam logic [N_CS-1:0] CS_OFF = {N_CS{1'b1}};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     adr = 32'd0, wdat = 32'd0;
  logic            we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [3:0]      sel = 4'd0;
  logic            ack_o, spi_clk_o, spi_data_o, spi_data_i;
  logic [31:0]     dat_o;
  logic [N_CS-1:0] spi_cs_n_o;
  logic            miso_loop = 1'b1, miso_const = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  int              n_r, fall_r, tog_r, first_tog_r, last_tog_r;
  logic            ack_seen_r, ack_or;
  logic [31:0]     cap_r, rdat_r;
  logic [N_CS-1:0] cs_and_r, cs_ack_r;

  assign spi_data_i = miso_loop ? spi_data_o : miso_const;

  always #5 clk = ~clk;

  wb_spi_master #(.N_CS(N_CS), .DEFAULT_DIV(1), .DEFAULT_CPOL(0), .DEFAULT_CPHA(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adr_i      (adr),
    .dat_i      (wdat),
    .we_i       (we),
    .sel_i      (sel),
    .stb_i      (stb),
    .cyc_i      (cyc),
    .ack_o      (ack_o),
    .dat_o      (dat_o),
    .spi_clk_o  (spi_clk_o),
    .spi_data_o (spi_data_o),
    .spi_data_i (spi_data_i),
    .spi_cs_n_o (spi_cs_n_o)
  );

  function automatic logic [31:0] rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One bus access; records latency, CS, SCLK and sampled-MOSI activity until ack.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic cpol, input logic cpha,
                     input logic b2b, input int budget);
    logic prev;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    adr = a; wdat = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
    n_r = 0; fall_r = 0; tog_r = 0; first_tog_r = 0; last_tog_r = 0;
    cap_r = 32'd0; rdat_r = 32'd0; cs_and_r = CS_OFF; cs_ack_r = CS_OFF;
    ack_seen_r = 1'b0;
    prev = spi_clk_o;
    for (int i = 0; i < budget && !ack_seen_r; i++) begin
      @(posedge clk);
      #1;
      n_r++;
      cs_and_r &= spi_cs_n_o;
      if (fall_r == 0 && spi_cs_n_o != CS_OFF) fall_r = n_r;
      if (spi_clk_o !== prev) begin
        tog_r++;
        if (first_tog_r == 0) first_tog_r = n_r;
        last_tog_r = n_r;
        if (spi_clk_o == (cpha ? cpol : ~cpol)) cap_r = {cap_r[30:0], spi_data_o};
      end
      prev = spi_clk_o;
      if (ack_o) begin
        ack_seen_r = 1'b1;
        rdat_r     = dat_o;
        cs_ack_r   = spi_cs_n_o;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  initial begin
    // Reset defaults.
    #23;
    push("rst_ack", 32'd0); push("rst_cs", 32'(CS_OFF)); push("rst_sclk", 32'd0);
    push("rst_mosi", 32'd0); push("rst_dat", 32'd0);
    chk(32'(ack_o)); chk(32'(spi_cs_n_o)); chk(32'(spi_clk_o)); chk(32'(spi_data_o)); chk(dat_o);
    @(negedge clk);
    rst_n = 1'b1;

    push("cfg_rd_ack", 32'd1); push("cfg_rd_lat", 32'd1); push("cfg_rd_val", 32'h001);
    bus(1'b0, 32'h80, 32'd0, 4'b1111, 1'b0, 1'b0, 1'b0, 50);
    chk(32'(ack_seen_r)); chk(32'(n_r)); chk(rdat_r);
    push("data_rd_val", 32'd0);
    bus(1'b0, 32'h00, 32'd0, 4'b1111, 1'b0, 1'b0, 1'b0, 50);
    chk(rdat_r);

    // Mode 0, div 1, CS1, 8-bit loopback.
    push("m0_ack", 32'd1); push("m0_lat", 32'd36); push("m0_cs_fall", 32'd1);
    push("m0_cs", 32'b101); push("m0_cs_at_ack", 32'(CS_OFF)); push("m0_toggles", 32'd16);
    push("m0_first_sclk", 32'd3); push("m0_mosi", 32'hA5); push("m0_rx", 32'hA5);
    bus(1'b1, 32'h10, 32'hFFFF_FFA5, 4'b0001, 1'b0, 1'b0, 1'b0, 500);
    chk(32'(ack_seen_r)); chk(32'(n_r)); chk(32'(fall_r)); chk(32'(cs_and_r)); chk(32'(cs_ack_r));
    chk(32'(tog_r)); chk(32'(first_tog_r)); chk(cap_r); chk(rdat_r);

    // Mode 3, div 3, LSB-first, 16-bit, MISO tied high.
    push("cfg_wr_lat", 32'd1); push("m3_sclk_idle", 32'd1);
    bus(1'b1, 32'h80, 32'h0000_0703, 4'b1111, 1'b0, 1'b0, 1'b0, 50);
    chk(32'(n_r)); chk(32'(spi_clk_o));
    push("cfg_rd_703", 32'h703);
    bus(1'b0, 32'h80, 32'd0, 4'b1111, 1'b0, 1'b0, 1'b0, 50);
    chk(rdat_r);
    miso_loop = 1'b0; miso_const = 1'b1;
    push("m3_lat", 32'd136); push("m3_cs", 32'b110); push("m3_toggles", 32'd32);
    push("m3_first_sclk", 32'd5); push("m3_sclk_span", 32'd124);
    push("m3_mosi", rev(32'h1234, 16)); push("m3_rx", 32'hFFFF);
    bus(1'b1, 32'h00, 32'hABCD_1234, 4'b0011, 1'b1, 1'b1, 1'b0, 500);
    chk(32'(n_r)); chk(32'(cs_and_r)); chk(32'(tog_r)); chk(32'(first_tog_r));
    chk(32'(last_tog_r - first_tog_r)); chk(cap_r); chk(rdat_r);

    // 32-bit to out-of-range CS, then an immediate follow-up transfer.
    miso_loop = 1'b1;
    bus(1'b1, 32'h80, 32'h0000_0001, 4'b1111, 1'b0, 1'b0, 1'b0, 50);
    push("w32_lat", 32'd132); push("w32_cs", 32'(CS_OFF)); push("w32_toggles", 32'd64);
    push("w32_mosi", 32'hDEAD_BEEF); push("w32_rx", 32'hDEAD_BEEF);
    bus(1'b1, 32'h70, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 1'b0, 500);
    chk(32'(n_r)); chk(32'(cs_and_r)); chk(32'(tog_r)); chk(cap_r); chk(rdat_r);
    push("b2b_cs_fall", 32'd2); push("b2b_lat", 32'd37); push("b2b_cs", 32'b110);
    push("b2b_rx", 32'h3C);
    bus(1'b1, 32'h00, 32'h0000_003C, 4'b0001, 1'b0, 1'b0, 1'b1, 500);
    chk(32'(fall_r)); chk(32'(n_r)); chk(32'(cs_and_r)); chk(rdat_r);

    // Unsupported byte select: immediate ack, no SPI activity, RX kept.
    push("bad_sel_lat", 32'd1); push("bad_sel_toggles", 32'd0); push("bad_sel_cs", 32'(CS_OFF));
    bus(1'b1, 32'h00, 32'h0000_00FF, 4'b0110, 1'b0, 1'b0, 1'b0, 50);
    chk(32'(n_r)); chk(32'(tog_r)); chk(32'(cs_and_r));
    push("bad_sel_rx", 32'h3C);
    bus(1'b0, 32'h00, 32'd0, 4'b1111, 1'b0, 1'b0, 1'b0, 50);
    chk(rdat_r);

    // Reset asserted around bit 5 of a transfer.
    @(posedge clk);
    #1;
    adr = 32'h00; wdat = 32'h5A; we = 1'b1; sel = 4'b0001; stb = 1'b1; cyc = 1'b1;
    repeat (23) @(posedge clk);
    #3;
    push("mid_cs_active", 32'b110);
    chk(32'(spi_cs_n_o));
    rst_n = 1'b0;
    #1;
    push("arst_ack", 32'd0); push("arst_cs", 32'(CS_OFF)); push("arst_sclk", 32'd0);
    push("arst_mosi", 32'd0); push("arst_dat", 32'd0);
    chk(32'(ack_o)); chk(32'(spi_cs_n_o)); chk(32'(spi_clk_o)); chk(32'(spi_data_o)); chk(dat_o);
    ack_or = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      ack_or |= ack_o;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      ack_or |= ack_o;
    end
    push("arst_no_ack", 32'd0);
    chk(32'(ack_or));
    push("post_rst_lat", 32'd36); push("post_rst_cs", 32'b011); push("post_rst_rx", 32'h5A);
    bus(1'b1, 32'h20, 32'h0000_005A, 4'b0001, 1'b0, 1'b0, 1'b0, 500);
    chk(32'(n_r)); chk(32'(cs_and_r)); chk(rdat_r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
